bounce_game_ctrl: RTL
=====================

BOUNCE_GAME_CTRL -- requirements
Module: bounce_game_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports clk and reset_n.
REQ-002 clk  input  1  system clock, pixel-domain clock shared with the text overlay.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  debounced start/jump button level (T18); only its rising edge is used.
REQ-005 frame_tick  input  1  one-cycle pulse per video frame (60 Hz).
REQ-006 hit  input  1  one-cycle pulse when the ball scores.
REQ-007 miss  input  1  one-cycle pulse when the ball is lost.
REQ-008 ball  output  2  spare balls remaining, fed to the overlay ball field.
REQ-009 dig0, dig1  output  4 each  BCD score ones and tens, fed to the overlay score field.
REQ-010 graph_still  output  1  freezes the graphics engine when high.
REQ-011 text_en  output  3  {logo_en, rule_en, over_en} region enables for the text overlay.

Function
REQ-012 The state machine SHALL have the states NEWGAME, PLAY, NEWBALL and OVER.
REQ-013 start_edge SHALL be start AND NOT start_q, where start_q is start registered once.
REQ-014 NEWGAME: on start_edge, go to PLAY and clear dig1:dig0 to 00; otherwise hold.
REQ-015 PLAY: a hit SHALL increment the score in BCD (09->10, 99->00 wrap).
REQ-016 PLAY, miss with ball>0: decrement ball, load the timer, and go to NEWBALL.
REQ-017 PLAY, miss with ball==0: load the timer and go to OVER; ball stays 0.
REQ-018 PLAY, hit and miss in the same cycle: the hit SHALL be counted and the miss SHALL also be processed as above.
REQ-019 hit and miss SHALL be ignored in every state other than PLAY.
REQ-020 Timer: 7-bit down-counter, loaded with TIMER_LOAD=119, decremented on frame_tick while nonzero; timer_done = (timer==0).
REQ-021 NEWBALL: go to PLAY only on start_edge while timer_done; start edges while the timer is nonzero SHALL be ignored.
REQ-022 OVER: when timer_done, go to NEWGAME and reload ball to BALL_INIT=3; the score SHALL be retained until the next start.
REQ-023 Outputs SHALL be Moore (decoded from registered state) and change one cycle after the transition.
REQ-024 graph_still SHALL be 0 only in PLAY.
REQ-025 text_en SHALL be: NEWGAME=3'b110, PLAY=3'b010, NEWBALL=3'b010, OVER=3'b011.
REQ-026 ball, dig0 and dig1 SHALL be driven directly from registers.

Reset
REQ-027 On reset_n low, the block SHALL enter NEWGAME asynchronously with ball=3, dig0=dig1=0, timer=0, start_q=0, graph_still=1 and text_en=3'b110.
REQ-028 Reset asserted mid-game SHALL abandon the game immediately, with no residual timer or score state.
REQ-029 After reset release, a start held high SHALL not count as an edge until it has been seen low.

Structure
REQ-030 The package bounce_pkg SHALL hold the state enum, TIMER_LOAD, BALL_INIT and the text_en bit positions.
REQ-031 The 2-digit BCD score counter SHALL be a sub-module bounce_bcd_counter (inputs clr, inc; outputs dig0, dig1).
REQ-032 Target size SHALL be 150-250 lines of RTL.

Verification
REQ-033 Reset, then a start pulse -> after 2 cycles PLAY, graph_still=0, text_en=010, dig=00, ball=3.
REQ-034 12 hit pulses in PLAY -> dig1=1, dig0=2; from 99, one hit -> 00.
REQ-035 Miss in PLAY with ball=3 -> NEWBALL, ball=2; start at tick 50 is ignored; start after 120 ticks -> PLAY.
REQ-036 Four misses with restarts -> OVER after the fourth miss, text_en=011; after 120 ticks -> NEWGAME, ball=3, score retained; next start -> score 00.
REQ-037 Simultaneous hit and miss in PLAY with score 05, ball=1 -> score 06, ball=0, state NEWBALL.
REQ-038 reset_n asserted mid-NEWBALL with the timer at 60 -> immediately NEWGAME, ball=3, dig=00, graph_still=1.

Source files
------------

// File: rtl/bounce_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bounce_pkg
//  Brief    : Shared state encoding and constants for the bounce game control.
//  Revision : 1.0
// ============================================================================
package bounce_pkg;

    typedef enum logic [1:0] {
        ST_NEWGAME = 2'd0,
        ST_PLAY    = 2'd1,
        ST_NEWBALL = 2'd2,
        ST_OVER    = 2'd3
    } game_state_t;

    // About two seconds of frames at 60 Hz between balls and before a new game.
    localparam logic [6:0] TIMER_LOAD = 7'd119;
    localparam logic [1:0] BALL_INIT  = 2'd3;

    localparam int LOGO_EN_BIT = 2;
    localparam int RULE_EN_BIT = 1;
    localparam int OVER_EN_BIT = 0;

endpackage
`default_nettype wire

// File: rtl/bounce_bcd_counter.sv
`default_nettype none
// ============================================================================
//  Module   : bounce_bcd_counter
//  Brief    : Two-digit BCD score counter, 00..99 with wrap, clear over inc.
//  Revision : 1.0
// ============================================================================
module bounce_bcd_counter (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] dig0,
    output logic [3:0] dig1
);

    logic [3:0] r_dig0;
    logic [3:0] r_dig1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dig0 <= 4'd0;
            r_dig1 <= 4'd0;
        end else if (clr) begin
            r_dig0 <= 4'd0;
            r_dig1 <= 4'd0;
        end else if (inc) begin
            if (r_dig0 == 4'd9) begin
                r_dig0 <= 4'd0;
                r_dig1 <= (r_dig1 == 4'd9) ? 4'd0 : r_dig1 + 4'd1;
            end else begin
                r_dig0 <= r_dig0 + 4'd1;
            end
        end
    end

    assign dig0 = r_dig0;
    assign dig1 = r_dig1;

endmodule
`default_nettype wire

// File: rtl/bounce_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : bounce_game_ctrl
//  Brief    : Game flow control (new game / play / new ball / over) for the
//             bounce game, driving score, ball count and overlay enables.
//  Revision : 1.0
// ============================================================================
module bounce_game_ctrl
    import bounce_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       frame_tick,
    input  logic       hit,
    input  logic       miss,
    output logic [1:0] ball,
    output logic [3:0] dig0,
    output logic [3:0] dig1,
    output logic       graph_still,
    output logic [2:0] text_en
);

    game_state_t r_state;
    game_state_t w_state_next;

    logic       r_start_q;
    logic       r_start_armed;
    logic [6:0] r_timer;
    logic [1:0] r_ball;

    logic       w_start_edge;
    logic       w_timer_done;
    logic       w_timer_load;
    logic       w_ball_dec;
    logic       w_ball_reload;
    logic       w_score_clr;
    logic       w_score_inc;
    logic       w_graph_still;
    logic [2:0] w_text_en;

    // A button already held at reset release must be seen low before it counts.
    assign w_start_edge = start & ~r_start_q & r_start_armed;
    assign w_timer_done = (r_timer == 7'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_start_q     <= 1'b0;
            r_start_armed <= 1'b0;
        end else begin
            r_start_q     <= start;
            r_start_armed <= r_start_armed | ~start;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_NEWGAME;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_timer_load  = 1'b0;
        w_ball_dec    = 1'b0;
        w_ball_reload = 1'b0;
        w_score_clr   = 1'b0;
        w_score_inc   = 1'b0;
        w_graph_still = 1'b1;
        w_text_en     = 3'b000;

        case (r_state)
            ST_NEWGAME: begin
                if (w_start_edge) begin
                    w_state_next = ST_PLAY;
                    w_score_clr  = 1'b1;
                end
            end
            ST_PLAY: begin
                w_score_inc = hit;
                if (miss) begin
                    w_timer_load = 1'b1;
                    if (r_ball != 2'd0) begin
                        w_ball_dec   = 1'b1;
                        w_state_next = ST_NEWBALL;
                    end else begin
                        w_state_next = ST_OVER;
                    end
                end
            end
            ST_NEWBALL: begin
                if (w_start_edge && w_timer_done) begin
                    w_state_next = ST_PLAY;
                end
            end
            ST_OVER: begin
                if (w_timer_done) begin
                    w_state_next  = ST_NEWGAME;
                    w_ball_reload = 1'b1;
                end
            end
            default: w_state_next = ST_NEWGAME;
        endcase

        // Moore decode of the registered state.
        w_graph_still = (r_state != ST_PLAY);
        w_text_en[RULE_EN_BIT] = 1'b1;
        w_text_en[LOGO_EN_BIT] = (r_state == ST_NEWGAME);
        w_text_en[OVER_EN_BIT] = (r_state == ST_OVER);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_timer <= 7'd0;
        end else if (w_timer_load) begin
            r_timer <= TIMER_LOAD;
        end else if (frame_tick && !w_timer_done) begin
            r_timer <= r_timer - 7'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ball <= BALL_INIT;
        end else if (w_ball_reload) begin
            r_ball <= BALL_INIT;
        end else if (w_ball_dec) begin
            r_ball <= r_ball - 2'd1;
        end
    end

    bounce_bcd_counter u_score (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (w_score_clr),
        .inc     (w_score_inc),
        .dig0    (dig0),
        .dig1    (dig1)
    );

    assign ball        = r_ball;
    assign graph_still = w_graph_still;
    assign text_en     = w_text_en;

endmodule
`default_nettype wire
